// File: rtl/lutram_fifo64.sv
// rtl/lutram_fifo64.sv - 64-deep FWFT FIFO on 64x1 LUT-RAM bit-slices with a registered valid/ready output stage
// Optional feature macro: FIFO_LEVEL_EN adds the registered level output (0..65).
module lutram_fifo64 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] wrData,
  input  logic             wrEn,
  output logic             wrFull,
  output logic [WIDTH-1:0] rdData,
  output logic             rdValid,
  input  logic             rdReady,
  output logic             overflow
`ifdef FIFO_LEVEL_EN
  ,
  output logic [6:0]       level
`endif
);

  logic [6:0]       r_wp;
  logic [6:0]       r_rp;
  logic [6:0]       w_cnt;
  logic [6:0]       w_wp_nxt;
  logic [6:0]       w_rp_nxt;
  logic             w_wr;
  logic             w_load;
  logic             w_valid_nxt;
  logic [WIDTH-1:0] w_ram_q;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ovf;

  // Occupancy never exceeds 64, so bit 6 of the difference is exactly cnt==64.
  assign w_cnt    = r_wp - r_rp;
  assign wrFull   = w_cnt[6];
  assign w_wr     = wrEn & ~wrFull;
  assign w_load   = (w_cnt != 7'd0) & (~r_valid | rdReady);
  assign w_wp_nxt = r_wp + {6'd0, w_wr};
  assign w_rp_nxt = r_rp + {6'd0, w_load};

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_load) begin
      w_valid_nxt = 1'b1;
    end else if (rdReady) begin
      w_valid_nxt = 1'b0;
    end
  end

  // One 64x1 slice per data bit: clocked write, asynchronous read, no reset.
  for (genvar b = 0; b < WIDTH; b++) begin : g_slice
    logic [63:0] r_bits;
    always_ff @(posedge CLK) begin
      if (w_wr) begin
        r_bits[r_wp[5:0]] <= wrData[b];
      end
    end
    assign w_ram_q[b] = r_bits[r_rp[5:0]];
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_wp    <= 7'd0;
      r_rp    <= 7'd0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wp    <= w_wp_nxt;
      r_rp    <= w_rp_nxt;
      r_valid <= w_valid_nxt;
      if (w_load) begin
        r_data <= w_ram_q;
      end
      if (wrEn & wrFull) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign rdData   = r_data;
  assign rdValid  = r_valid;
  assign overflow = r_ovf;

`ifdef FIFO_LEVEL_EN
  logic [6:0] r_level;
  logic [6:0] w_level_nxt;

  assign w_level_nxt = (w_wp_nxt - w_rp_nxt) + {6'd0, w_valid_nxt};

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_level <= 7'd0;
    end else begin
      r_level <= w_level_nxt;
    end
  end

  assign level = r_level;
`endif

endmodule

// File: tb/tb_lutram_fifo64.sv
// tb/tb_lutram_fifo64.sv - directed scoreboard bench for lutram_fifo64
// Build with FIFO_LEVEL_EN defined to also check the level output.
module tb_lutram_fifo64;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] wrData;
  logic        wrEn;
  logic        wrFull;
  logic [31:0] rdData;
  logic        rdValid;
  logic        rdReady;
  logic        overflow;
`ifdef FIFO_LEVEL_EN
  logic [6:0]  level;
`endif

  lutram_fifo64 #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .wrData   (wrData),
    .wrEn     (wrEn),
    .wrFull   (wrFull),
    .rdData   (rdData),
    .rdValid  (rdValid),
    .rdReady  (rdReady),
    .overflow (overflow)
`ifdef FIFO_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Scoreboard: every entry the FIFO holds, head first; m_valid says whether the head sits in the output register.
  logic [31:0] q[$];
  logic        m_valid;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ram_cnt();
    return q.size() - int'(m_valid);
  endfunction

  task automatic check_outputs();
    chk("rdValid", {31'd0, rdValid}, {31'd0, m_valid});
    chk("wrFull", {31'd0, wrFull}, {31'd0, ram_cnt() == 64});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (m_valid) begin
      chk("rdData", rdData, q[0]);
    end
`ifdef FIFO_LEVEL_EN
    chk("level", {25'd0, level}, q.size());
`endif
  endtask

  // Called at a falling edge: check, drive, advance the model across one rising edge.
  task automatic step(input logic we, input logic [31:0] d, input logic rdy);
    logic wr, load, pop;
    check_outputs();
    wrEn    = we;
    wrData  = d;
    rdReady = rdy;
    wr   = we && (ram_cnt() != 64);
    load = (ram_cnt() != 0) && (!m_valid || rdy);
    pop  = m_valid && rdy;
    if (we && !wr) m_ovf = 1'b1;
    if (pop) void'(q.pop_front());
    if (wr) q.push_back(d);
    if (load) m_valid = 1'b1;
    else if (pop) m_valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
  task automatic pulse_reset();
    wrEn    = 1'b0;
    rdReady = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("rst_rdValid", {31'd0, rdValid}, 32'd0);
    chk("rst_wrFull", {31'd0, wrFull}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_rdData", rdData, 32'd0);
`ifdef FIFO_LEVEL_EN
    chk("rst_level", {25'd0, level}, 32'd0);
`endif
    q.delete();
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) begin
      step(1'b0, 32'd0, 1'b1);
    end
    chk("drain_empty", q.size(), 32'd0);
    step(1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset   = 1'b1;
    wrEn    = 1'b0;
    wrData  = 32'd0;
    rdReady = 1'b0;
    q.delete();
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("init_rdData", rdData, 32'd0);
    Reset = 1'b0;

    // Single write with rdReady low: visible after the second edge and held.
    step(1'b1, 32'h11, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0);
    chk("single_head", rdData, 32'h11);
    drain(4);

    // Fill to 65 entries, then one rejected write, then drain in order.
    for (int i = 0; i <= 64; i++) step(1'b1, i, 1'b0);
    chk("fill_wrFull", {31'd0, wrFull}, 32'd1);
    step(1'b1, 32'hDEAD, 1'b0);
    chk("fill_overflow", {31'd0, overflow}, 32'd1);
    step(1'b0, 32'd0, 1'b0);
    drain(80);

    // Full boundary: write and read together at cnt==64 drops the write; 0xAB goes in next.
    pulse_reset();
    for (int i = 0; i <= 64; i++) step(1'b1, 32'h100 + i, 1'b0);
    step(1'b1, 32'hEE, 1'b1);
    chk("bound_wrFull_clear", {31'd0, wrFull}, 32'd0);
    step(1'b1, 32'hAB, 1'b0);
    chk("bound_last", q[q.size()-1], 32'hAB);

    // Reset mid-operation with entries queued and overflow set.
    pulse_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 32'h200 + i, 1'b0);
    pulse_reset();
    step(1'b1, 32'h5A, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    chk("post_rst_head", rdData, 32'h5A);
    drain(4);

    // Streaming 200 words with rdReady high: pointers wrap three times.
    for (int i = 0; i < 200; i++) step(1'b1, i, 1'b1);
    drain(8);

    // Backpressure: rdReady alternates while writing every cycle.
    for (int i = 0; i < 40; i++) step(1'b1, 32'h1000 + i, (i % 2) == 0);
    drain(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
